// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick with average period
// (act_int + 1 + act_frac/2^FRAC_W) clocks, plus mid-bit and bit ticks.
`timescale 1ns/1ps

module baud_gen_frac #(
   parameter int unsigned INT_W    = 16,
   parameter int unsigned FRAC_W   = 4,
   parameter int unsigned OSR      = 16,
   parameter int unsigned RST_INT  = 324,
   parameter int unsigned RST_FRAC = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync_clr,
   input  logic              load,
   input  logic [INT_W-1:0]  dvsr_int,
   input  logic [FRAC_W-1:0] dvsr_frac,
   output logic              tick,
   output logic              mid_tick,
   output logic              bit_tick,
   output logic              pend
);

   localparam int unsigned CNT_W = INT_W + 1;
   localparam int unsigned SUM_W = FRAC_W + 1;
   localparam int unsigned OS_W  = (OSR > 2) ? $clog2(OSR) : 1;

   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);

   // phase state
   logic [CNT_W-1:0]  r_cnt;
   logic [FRAC_W-1:0] r_acc;
   logic              r_ext;
   logic [OS_W-1:0]   r_os_cnt;

   // active and shadow divisors
   logic [INT_W-1:0]  r_act_int;
   logic [FRAC_W-1:0] r_act_frac;
   logic [INT_W-1:0]  r_pend_int;
   logic [FRAC_W-1:0] r_pend_frac;
   logic              r_pend_vld;

   // next-state values
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [FRAC_W-1:0] w_acc_nxt;
   logic              w_ext_nxt;
   logic [OS_W-1:0]   w_os_nxt;
   logic [INT_W-1:0]  w_act_int_nxt;
   logic [FRAC_W-1:0] w_act_frac_nxt;
   logic [INT_W-1:0]  w_pend_int_nxt;
   logic [FRAC_W-1:0] w_pend_frac_nxt;
   logic              w_pend_vld_nxt;
   logic              w_tick_nxt;
   logic              w_mid_nxt;
   logic              w_bit_nxt;

   logic [CNT_W-1:0]  w_term;
   logic              w_wrap;
   logic [SUM_W-1:0]  w_acc_sum;
   logic [OS_W-1:0]   w_os_inc;

   // Terminal count is one bit wider so an all-ones divisor plus carry cannot wrap.
   assign w_term    = {1'b0, r_act_int} + CNT_W'(r_ext);
   assign w_wrap    = (r_cnt == w_term);
   assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
   assign w_os_inc  = (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);

   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_acc_nxt       = r_acc;
      w_ext_nxt       = r_ext;
      w_os_nxt        = r_os_cnt;
      w_act_int_nxt   = r_act_int;
      w_act_frac_nxt  = r_act_frac;
      w_pend_int_nxt  = r_pend_int;
      w_pend_frac_nxt = r_pend_frac;
      w_pend_vld_nxt  = r_pend_vld;
      w_tick_nxt      = 1'b0;
      w_mid_nxt       = 1'b0;
      w_bit_nxt       = 1'b0;

      if (sync_clr) begin
         // Re-align phase; any waiting or same-cycle divisor takes effect now.
         w_cnt_nxt      = '0;
         w_acc_nxt      = '0;
         w_ext_nxt      = 1'b0;
         w_os_nxt       = '0;
         w_pend_vld_nxt = 1'b0;
         if (load) begin
            w_act_int_nxt  = dvsr_int;
            w_act_frac_nxt = dvsr_frac;
         end else if (r_pend_vld) begin
            w_act_int_nxt  = r_pend_int;
            w_act_frac_nxt = r_pend_frac;
         end
      end else if (!en) begin
         // Idle: a load is safe to apply directly and restarts the phase.
         if (load) begin
            w_act_int_nxt  = dvsr_int;
            w_act_frac_nxt = dvsr_frac;
            w_cnt_nxt      = '0;
            w_acc_nxt      = '0;
            w_ext_nxt      = 1'b0;
            w_os_nxt       = '0;
            w_pend_vld_nxt = 1'b0;
         end
      end else if (w_wrap) begin
         w_cnt_nxt  = '0;
         w_os_nxt   = w_os_inc;
         w_tick_nxt = 1'b1;
         w_mid_nxt  = (r_os_cnt == OS_MID);
         w_bit_nxt  = (r_os_cnt == OS_LAST);
         if (load) begin
            w_act_int_nxt  = dvsr_int;
            w_act_frac_nxt = dvsr_frac;
            w_acc_nxt      = '0;
            w_ext_nxt      = 1'b0;
            w_pend_vld_nxt = 1'b0;
         end else if (r_pend_vld) begin
            w_act_int_nxt  = r_pend_int;
            w_act_frac_nxt = r_pend_frac;
            w_acc_nxt      = '0;
            w_ext_nxt      = 1'b0;
            w_pend_vld_nxt = 1'b0;
         end else begin
            // Carry out of the accumulator stretches the next period by one clock.
            w_ext_nxt = w_acc_sum[FRAC_W];
            w_acc_nxt = w_acc_sum[FRAC_W-1:0];
         end
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
         if (load) begin
            w_pend_int_nxt  = dvsr_int;
            w_pend_frac_nxt = dvsr_frac;
            w_pend_vld_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_ext       <= 1'b0;
         r_os_cnt    <= '0;
         r_act_int   <= INT_W'(RST_INT);
         r_act_frac  <= FRAC_W'(RST_FRAC);
         r_pend_int  <= '0;
         r_pend_frac <= '0;
         r_pend_vld  <= 1'b0;
         tick        <= 1'b0;
         mid_tick    <= 1'b0;
         bit_tick    <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_acc       <= w_acc_nxt;
         r_ext       <= w_ext_nxt;
         r_os_cnt    <= w_os_nxt;
         r_act_int   <= w_act_int_nxt;
         r_act_frac  <= w_act_frac_nxt;
         r_pend_int  <= w_pend_int_nxt;
         r_pend_frac <= w_pend_frac_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         tick        <= w_tick_nxt;
         mid_tick    <= w_mid_nxt;
         bit_tick    <= w_bit_nxt;
      end
   end

   assign pend = r_pend_vld;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac (default parameters).
`timescale 1ns/1ps

module tb_baud_gen_frac;

   logic        clk;
   logic        reset;
   logic        en;
   logic        sync_clr;
   logic        load;
   logic [15:0] dvsr_int;
   logic [3:0]  dvsr_frac;
   logic        tick;
   logic        mid_tick;
   logic        bit_tick;
   logic        pend;

   int n_tests = 0;
   int n_fail  = 0;

   baud_gen_frac dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sync_clr  (sync_clr),
      .load      (load),
      .dvsr_int  (dvsr_int),
      .dvsr_frac (dvsr_frac),
      .tick      (tick),
      .mid_tick  (mid_tick),
      .bit_tick  (bit_tick),
      .pend      (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until tick is seen; n = -1 if the bound expires.
   task automatic wait_tick(input int limit, output int n, output logic saw_pend);
      n = 0;
      saw_pend = 1'b0;
      do begin
         step();
         n++;
         if (pend === 1'b1) saw_pend = 1'b1;
      end while (tick !== 1'b1 && n < limit);
      if (tick !== 1'b1) n = -1;
   endtask

   // Reset, then load the divisor while idle and enable counting.
   task automatic start(input int di, input int df);
      reset = 1'b1; en = 1'b0; load = 1'b0; sync_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      dvsr_int = 16'(di); dvsr_frac = 4'(df); load = 1'b1;
      step();
      load = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_reset();
      int n; logic sp;
      reset = 1'b1; en = 1'b1; load = 1'b0; sync_clr = 1'b0;
      step(); step();
      n_tests++;
      if ({tick, mid_tick, bit_tick, pend} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, expected 0000", {tick, mid_tick, bit_tick, pend});
      end
      reset = 1'b0;
      wait_tick(400, n, sp);
      n_tests++;
      if (n !== 325) begin n_fail++; $display("FAIL reset_first_tick: got %0d, expected 325", n); end
      wait_tick(400, n, sp);
      n_tests++;
      if (n !== 325) begin n_fail++; $display("FAIL reset_period2: got %0d, expected 325", n); end
      wait_tick(400, n, sp);
      n_tests++;
      if (n !== 326) begin n_fail++; $display("FAIL reset_period3: got %0d, expected 326", n); end
   endtask

   task automatic test_integer();
      int n; logic sp;
      start(3, 0);
      n_tests++;
      if (pend !== 1'b0) begin n_fail++; $display("FAIL int_idle_load_pend: got %b, expected 0", pend); end
      for (int i = 1; i <= 16; i++) begin
         wait_tick(20, n, sp);
         n_tests++;
         if (n !== 4 || mid_tick !== (i == 8) || bit_tick !== (i == 16)) begin
            n_fail++;
            $display("FAIL int_tick%0d: period %0d mid %b bit %b, expected 4 %b %b",
                     i, n, mid_tick, bit_tick, (i == 8), (i == 16));
         end
      end
      n = 0;
      do begin step(); n++; end while (bit_tick !== 1'b1 && n < 200);
      n_tests++;
      if (n !== 64) begin n_fail++; $display("FAIL int_bit_period: got %0d, expected 64", n); end
   endtask

   task automatic test_fraction();
      int n; int sum; logic sp;
      int exp_p [7] = '{4, 4, 5, 4, 5, 4, 5};
      start(3, 8);
      for (int i = 0; i < 7; i++) begin
         wait_tick(20, n, sp);
         n_tests++;
         if (n !== exp_p[i]) begin n_fail++; $display("FAIL frac_period%0d: got %0d, expected %0d", i, n, exp_p[i]); end
      end
      sum = 0;
      for (int i = 0; i < 16; i++) begin
         wait_tick(20, n, sp);
         sum += n;
      end
      n_tests++;
      if (sum !== 72) begin n_fail++; $display("FAIL frac_16_ticks: got %0d cycles, expected 72", sum); end
   endtask

   task automatic test_runtime_update();
      int n; logic sp;
      start(3, 0);
      wait_tick(20, n, sp);
      step(); step();
      dvsr_int = 16'd9; dvsr_frac = 4'd0; load = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if (pend !== 1'b1) begin n_fail++; $display("FAIL upd_pend_set: got %b, expected 1", pend); end
      wait_tick(20, n, sp);
      n_tests++;
      if (n + 3 !== 4) begin n_fail++; $display("FAIL upd_old_period: got %0d, expected 4", n + 3); end
      n_tests++;
      if (pend !== 1'b0) begin n_fail++; $display("FAIL upd_pend_clr: got %b, expected 0", pend); end
      for (int i = 0; i < 2; i++) begin
         wait_tick(30, n, sp);
         n_tests++;
         if (n !== 10) begin n_fail++; $display("FAIL upd_new_period%0d: got %0d, expected 10", i, n); end
      end
   endtask

   task automatic test_coincident();
      int n; logic sp;
      start(3, 0);
      wait_tick(20, n, sp);
      step(); step(); step();
      dvsr_int = 16'd5; dvsr_frac = 4'd0; load = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if (tick !== 1'b1 || pend !== 1'b0) begin
         n_fail++; $display("FAIL coin_edge: tick %b pend %b, expected 1 0", tick, pend);
      end
      wait_tick(20, n, sp);
      n_tests++;
      if (n !== 6 || sp !== 1'b0) begin
         n_fail++; $display("FAIL coin_period: got %0d pend_seen %b, expected 6 0", n, sp);
      end
   endtask

   task automatic test_sync_clr();
      int n; int k; int mid_at; logic sp;
      start(3, 0);
      for (int i = 0; i < 7; i++) wait_tick(20, n, sp);
      step();
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      n_tests++;
      if ({tick, mid_tick, bit_tick} !== 3'b0) begin
         n_fail++; $display("FAIL clr_outputs: got %b, expected 000", {tick, mid_tick, bit_tick});
      end
      wait_tick(20, n, sp);
      n_tests++;
      if (n !== 4 || mid_tick !== 1'b0) begin
         n_fail++; $display("FAIL clr_first_tick: period %0d mid %b, expected 4 0", n, mid_tick);
      end
      k = 1; mid_at = 0;
      while (bit_tick !== 1'b1 && k < 40) begin
         wait_tick(20, n, sp);
         k++;
         if (mid_tick === 1'b1 && mid_at == 0) mid_at = k;
      end
      n_tests++;
      if (k !== 16 || mid_at !== 8) begin
         n_fail++; $display("FAIL clr_bit_tick: bit at %0d mid at %0d, expected 16 8", k, mid_at);
      end
   endtask

   task automatic test_edges();
      int n; int hi; logic any_tick; logic sp;
      start(0, 0);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (tick === 1'b1) hi++;
      end
      n_tests++;
      if (hi !== 8) begin n_fail++; $display("FAIL zero_div: tick high %0d of 8, expected 8", hi); end

      start(9, 0);
      wait_tick(30, n, sp);
      n_tests++;
      if (n !== 10) begin n_fail++; $display("FAIL hold_first: got %0d, expected 10", n); end
      step(); step(); step();
      en = 1'b0;
      any_tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tick !== 1'b0) any_tick = 1'b1;
      end
      en = 1'b1;
      n_tests++;
      if (any_tick !== 1'b0) begin n_fail++; $display("FAIL hold_no_tick: got tick, expected none"); end
      wait_tick(30, n, sp);
      n_tests++;
      if (n !== 7) begin n_fail++; $display("FAIL hold_resume: got %0d, expected 7", n); end

      start(3, 0);
      wait_tick(20, n, sp);
      reset = 1'b1;
      #1;
      n_tests++;
      if ({tick, mid_tick, bit_tick, pend} !== 4'b0) begin
         n_fail++; $display("FAIL async_reset: got %b, expected 0000", {tick, mid_tick, bit_tick, pend});
      end
      step();
      reset = 1'b0;
      wait_tick(400, n, sp);
      n_tests++;
      if (n !== 325) begin n_fail++; $display("FAIL reset_rate_restore: got %0d, expected 325", n); end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; sync_clr = 1'b0; load = 1'b0;
      dvsr_int = '0; dvsr_frac = '0;
      test_reset();
      test_integer();
      test_fraction();
      test_runtime_update();
      test_coincident();
      test_sync_clr();
      test_edges();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-rate generator; successor to the fixed 11-bit integer divider.
- Produces an oversample tick with average period (DVSR_INT + 1 + DVSR_FRAC/2^FRAC_W) clk cycles, plus a mid-bit tick and a bit tick derived from an OSR counter.
- Sits between the register interface and the UART RX/TX engines.
- Supports glitch-free runtime divisor update and synchronous re-alignment for RX start-bit detection.

Parameters:
- INT_W, 16, integer divisor width
- FRAC_W, 4, fractional divisor width
- OSR, 16, oversample ticks per bit (even, >= 2)
- RST_INT, 324, active integer divisor after reset
- RST_FRAC, 8, active fractional divisor after reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; counters hold while low
- sync_clr  in  1  synchronous clear of phase (cnt, acc, ext, os_cnt)
- load  in  1  one-cycle strobe; capture dvsr_int/dvsr_frac
- dvsr_int  in  INT_W  integer divisor (period-1 form)
- dvsr_frac  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle
- tick  out  1  oversample tick, one-cycle pulse
- mid_tick  out  1  pulse on tick where os_cnt == OSR/2-1
- bit_tick  out  1  pulse on tick where os_cnt == OSR-1
- pend  out  1  a loaded divisor is waiting to be applied

Behaviour:
- Reset (async, active-high) has priority over all inputs. On reset:
  - cnt, acc, ext and os_cnt go to 0.
  - act_int/act_frac go to RST_INT/RST_FRAC.
  - pend_vld goes to 0.
  - tick, mid_tick, bit_tick and pend all go to 0.
- Widths:
  - cnt is INT_W+1 bits.
  - Terminal term = act_int + ext, computed in INT_W+1 bits, so act_int = all-ones with ext = 1 does not wrap.
  - acc sum is FRAC_W+1 bits.
- Counting (en=1, sync_clr=0): wrap = (cnt == term).
  - On wrap: cnt <= 0; {ext, acc} <= acc + act_frac (the carry lengthens the NEXT period by one cycle); os_cnt <= (os_cnt == OSR-1) ? 0 : os_cnt + 1.
  - Otherwise: cnt <= cnt + 1.
- Outputs are registered.
  - tick <= en & wrap.
  - mid_tick <= en & wrap & (os_cnt == OSR/2-1), using os_cnt before increment.
  - bit_tick <= en & wrap & (os_cnt == OSR-1), using os_cnt before increment.
  - With en held high after reset, the first tick is high during the cycle after the (RST_INT+1)th enabled edge.
- Period length is term+1 cycles. act_int = 0 with act_frac = 0 gives tick high every cycle.
- en=0: cnt, acc, ext and os_cnt hold; all tick outputs are 0 on the next edge. Phase resumes unchanged when en returns high.
- load while en=1: inputs captured to pend_int/pend_frac and pend_vld <= 1.
  - At the next wrap edge: act <= pend, acc <= 0, ext <= 0, pend_vld <= 0.
  - If load coincides with a wrap edge, the load values are applied at that same edge directly and pend_vld stays 0.
  - A second load before the wrap overwrites pend (last write wins).
- load while en=0: act <= inputs immediately; cnt, acc, ext and os_cnt <= 0; pend_vld stays 0.
- sync_clr=1 (priority over en and wrap):
  - cnt, acc, ext and os_cnt <= 0; outputs <= 0.
  - Pending divisor (or a same-cycle load) is applied; pend_vld <= 0.
  - The next tick follows term+1 enabled edges after the clear.
- pend = pend_vld, registered.
- Reset mid-period: all state returns to reset values immediately; no residual tick.
- Implementation is plain counters plus shadow registers; no internal clock gating.

Test Plan:
- Integer rate: reset, load int=3 frac=0 with en=0, then en=1 -> tick every 4 cycles; mid_tick on the 8th tick; bit_tick on the 16th tick, then every 64 cycles.
- Fraction: int=3, frac=8 -> periods 4,4,5,4,5,...; exactly 72 clk cycles across any 16 consecutive ticks in steady state.
- Runtime update: running at int=3; load int=9 two cycles after a tick -> pend=1 until the next wrap; that period is still 4 cycles; following periods are 10 cycles; pend=0 after the wrap.
- Coincident load/wrap: load int=5 exactly at a wrap edge -> pend never rises; the next period is 6 cycles.
- sync_clr mid-period with os_cnt=7 -> outputs 0 next cycle; the next tick arrives after term+1 edges; bit_tick only after 16 more ticks.
- Edge/hold cases:
  - int=0, frac=0 -> tick constant 1.
  - en low for 10 cycles mid-period -> no ticks; phase resumes with the remaining count.
  - Async reset mid-period -> outputs 0 immediately; the RST_INT/RST_FRAC rate restores.
